// File: rtl/arb_client_if.sv
// Handshake/bus bundle between an arb_client and its arbiter, subsystem and TLP engine.
interface arb_client_if #(
  parameter int DESC_W     = 64,
  parameter int DEPTH_LOG2 = 2
);
  logic                  trn;
  logic                  drvn;
  logic                  reqep;
  logic [DESC_W-1:0]     desc_data;
  logic                  desc_valid;
  logic                  desc_ready;
  logic                  tlp_start;
  logic [DESC_W-1:0]     tlp_desc;
  logic                  tlp_done;
  logic [DEPTH_LOG2:0]   pending;
  logic                  timeout_err;

  // Client side (arb_client itself).
  modport master (
    input  trn, desc_data, desc_valid, tlp_done,
    output drvn, reqep, desc_ready, tlp_start, tlp_desc, pending, timeout_err
  );

  // Environment side (arbiter, subsystem, TLP engine).
  modport slave (
    output trn, desc_data, desc_valid, tlp_done,
    input  drvn, reqep, desc_ready, tlp_start, tlp_desc, pending, timeout_err
  );
endinterface

// File: rtl/arb_client.sv
// Requester-side arbiter client: queues TLP descriptors, requests the endpoint,
// launches one TLP per grant and releases the channel on done or watchdog expiry.
module arb_client #(
  parameter int DESC_W     = 64,
  parameter int DEPTH_LOG2 = 2,
  parameter int TMO_W      = 10
) (
  input  logic          clk,
  input  logic          rst,
  arb_client_if.master  bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_t;

  state_t                 state;
  logic [DESC_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic [DEPTH_LOG2:0]    count_nxt;
  logic [TMO_W-1:0]       wd;
  logic [TMO_W-1:0]       wd_inc;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign push   = bus.desc_valid & ~full;
  assign pop    = (state == IDLE) & bus.trn & ~empty;
  assign wd_inc = wd + TMO_W'(1);

  assign bus.desc_ready = ~full;
  assign bus.pending    = count;

  // Next FIFO occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (DEPTH_LOG2+1)'(1);
    else if (pop && !push)
      count_nxt = count - (DEPTH_LOG2+1)'(1);
  end

  // Descriptor storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.desc_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_nxt;
    end
  end

  // Grant/drive/release FSM with registered outputs.
  // reqep is computed from the post-edge occupancy and state so it tracks
  // "pending!=0 in IDLE" with no extra cycle of lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.drvn        <= 1'b0;
      bus.reqep       <= 1'b0;
      bus.tlp_start   <= 1'b0;
      bus.tlp_desc    <= '0;
      bus.timeout_err <= 1'b0;
      wd              <= '0;
    end else begin
      bus.tlp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state         <= DRIVE;
            bus.drvn      <= 1'b1;
            bus.tlp_start <= 1'b1;
            bus.tlp_desc  <= mem[rd_ptr];
            bus.reqep     <= 1'b0;
            wd            <= '0;
          end else begin
            bus.reqep <= (count_nxt != '0);
          end
        end
        DRIVE: begin
          bus.reqep <= 1'b0;
          if (bus.tlp_done) begin
            state    <= RELEASE;
            bus.drvn <= 1'b0;
          end else if (wd_inc == '1) begin
            state           <= RELEASE;
            bus.drvn        <= 1'b0;
            bus.timeout_err <= 1'b1;
          end else begin
            wd <= wd_inc;
          end
        end
        RELEASE: begin
          state     <= IDLE;
          bus.drvn  <= 1'b0;
          bus.reqep <= (count_nxt != '0);
        end
        default: begin
          state     <= IDLE;
          bus.drvn  <= 1'b0;
          bus.reqep <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arb_client.sv
// Directed bench for arb_client: vector table for grant/release/FIFO behaviour,
// hand sequences for wrap ordering, watchdog and mid-DRIVE reset.
module tb_arb_client;
  logic clk = 1'b0;
  logic rst;

  arb_client_if #(.DESC_W(64), .DEPTH_LOG2(2)) bus ();

  arb_client #(.DESC_W(64), .DEPTH_LOG2(2), .TMO_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        trn;
    logic        vld;
    logic        done;
    logic [63:0] d;
    logic        e_drvn;
    logic        e_reqep;
    logic        e_start;
    logic [63:0] e_desc;
    logic [2:0]  e_pend;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] sb[$];

  function automatic vec_t mk(logic trn, logic vld, logic done, logic [63:0] d,
                              logic e_drvn, logic e_reqep, logic e_start,
                              logic [63:0] e_desc, logic [2:0] e_pend, logic e_rdy);
    vec_t v;
    v.trn = trn; v.vld = vld; v.done = done; v.d = d;
    v.e_drvn = e_drvn; v.e_reqep = e_reqep; v.e_start = e_start;
    v.e_desc = e_desc; v.e_pend = e_pend; v.e_rdy = e_rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.trn = 1'b0; bus.desc_valid = 1'b0; bus.tlp_done = 1'b0; bus.desc_data = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    bus.desc_valid = 1'b1; bus.desc_data = d;
    tick();
    bus.desc_valid = 1'b0;
    sb.push_back(d);
  endtask

  // Grant, check launch of expected head, complete with tlp_done, return to IDLE.
  task automatic grant_one(input string tag);
    logic [63:0] exp;
    exp = sb.pop_front();
    bus.trn = 1'b1;
    tick();
    bus.trn = 1'b0;
    chk({tag, ".drvn"}, 64'(bus.drvn), 64'd1);
    chk({tag, ".start"}, 64'(bus.tlp_start), 64'd1);
    chk({tag, ".desc"}, bus.tlp_desc, exp);
    bus.tlp_done = 1'b1;
    tick();
    bus.tlp_done = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();
    // Reset state
    chk("rst.drvn", 64'(bus.drvn), 64'd0);
    chk("rst.reqep", 64'(bus.reqep), 64'd0);
    chk("rst.start", 64'(bus.tlp_start), 64'd0);
    chk("rst.desc", bus.tlp_desc, 64'd0);
    chk("rst.pend", 64'(bus.pending), 64'd0);
    chk("rst.rdy", 64'(bus.desc_ready), 64'd1);
    chk("rst.tmo", 64'(bus.timeout_err), 64'd0);

    //                trn vld done d       drvn req start desc    pend rdy
    // T1: push, grant 3 cycles later
    vecs.push_back(mk(0, 1, 0, 64'hA5,   0, 1, 0, 64'h0,  3'd1, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h0,  3'd1, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h0,  3'd1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 1, 64'hA5, 3'd0, 1));
    // T2: done 5 cycles into DRIVE, one RELEASE cycle, IDLE with empty FIFO
    vecs.push_back(mk(0, 0, 0, 64'h0,    1, 0, 0, 64'hA5, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    1, 0, 0, 64'hA5, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    1, 0, 0, 64'hA5, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    1, 0, 0, 64'hA5, 3'd0, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'hA5, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 0, 64'hA5, 3'd0, 1));
    // T4: default grant on empty FIFO, grant during DRIVE, done outside DRIVE
    vecs.push_back(mk(1, 0, 1, 64'h0,    0, 0, 0, 64'hA5, 3'd0, 1));
    vecs.push_back(mk(0, 1, 0, 64'h11,   0, 1, 0, 64'hA5, 3'd1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 1, 64'h11, 3'd0, 1));
    vecs.push_back(mk(0, 1, 0, 64'h22,   1, 0, 0, 64'h11, 3'd1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 0, 64'h11, 3'd1, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'h11, 3'd1, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h11, 3'd1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 1, 64'h22, 3'd0, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'h22, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 0, 64'h22, 3'd0, 1));
    // T3: fill to full, push+grant while full refuses the push
    vecs.push_back(mk(0, 1, 0, 64'h31,   0, 1, 0, 64'h22, 3'd1, 1));
    vecs.push_back(mk(0, 1, 0, 64'h32,   0, 1, 0, 64'h22, 3'd2, 1));
    vecs.push_back(mk(0, 1, 0, 64'h33,   0, 1, 0, 64'h22, 3'd3, 1));
    vecs.push_back(mk(0, 1, 0, 64'h34,   0, 1, 0, 64'h22, 3'd4, 0));
    vecs.push_back(mk(1, 1, 0, 64'h35,   1, 0, 1, 64'h31, 3'd3, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'h31, 3'd3, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h31, 3'd3, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 1, 64'h32, 3'd2, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'h32, 3'd2, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h32, 3'd2, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 1, 64'h33, 3'd1, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'h33, 3'd1, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 1, 0, 64'h33, 3'd1, 1));
    vecs.push_back(mk(1, 0, 0, 64'h0,    1, 0, 1, 64'h34, 3'd0, 1));
    vecs.push_back(mk(0, 0, 1, 64'h0,    0, 0, 0, 64'h34, 3'd0, 1));
    vecs.push_back(mk(0, 0, 0, 64'h0,    0, 0, 0, 64'h34, 3'd0, 1));

    foreach (vecs[i]) begin
      bus.trn = vecs[i].trn; bus.desc_valid = vecs[i].vld;
      bus.tlp_done = vecs[i].done; bus.desc_data = vecs[i].d;
      tick();
      chk($sformatf("v%0d.drvn", i), 64'(bus.drvn), 64'(vecs[i].e_drvn));
      chk($sformatf("v%0d.reqep", i), 64'(bus.reqep), 64'(vecs[i].e_reqep));
      chk($sformatf("v%0d.start", i), 64'(bus.tlp_start), 64'(vecs[i].e_start));
      chk($sformatf("v%0d.desc", i), bus.tlp_desc, vecs[i].e_desc);
      chk($sformatf("v%0d.pend", i), 64'(bus.pending), 64'(vecs[i].e_pend));
      chk($sformatf("v%0d.rdy", i), 64'(bus.desc_ready), 64'(vecs[i].e_rdy));
    end
    bus.trn = 1'b0; bus.desc_valid = 1'b0; bus.tlp_done = 1'b0;

    // Wrap: 6 pushes with grants interleaved, descriptors must emerge in order
    for (int i = 0; i < 6; i++) begin
      push(64'h40 + 64'(i));
      if (i == 1 || i == 3) grant_one($sformatf("wrap_g%0d", i));
    end
    chk("wrap.pend", 64'(bus.pending), 64'd4);
    chk("wrap.rdy", 64'(bus.desc_ready), 64'd0);
    for (int i = 0; i < 4; i++) grant_one($sformatf("wrap_d%0d", i));
    chk("wrap.empty", 64'(bus.pending), 64'd0);

    // T5: watchdog expiry after 1023 DRIVE cycles
    do_reset();
    push(64'h77);
    void'(sb.pop_front());
    bus.trn = 1'b1; tick(); bus.trn = 1'b0;
    repeat (1022) tick();
    chk("wd.drvn_hold", 64'(bus.drvn), 64'd1);
    chk("wd.tmo_pre", 64'(bus.timeout_err), 64'd0);
    tick();
    chk("wd.drvn_drop", 64'(bus.drvn), 64'd0);
    chk("wd.tmo_set", 64'(bus.timeout_err), 64'd1);
    repeat (5) tick();
    chk("wd.tmo_sticky", 64'(bus.timeout_err), 64'd1);
    do_reset();
    chk("wd.tmo_clr", 64'(bus.timeout_err), 64'd0);

    // T5b: done and timeout on the same edge -> counted as done
    push(64'h78);
    void'(sb.pop_front());
    bus.trn = 1'b1; tick(); bus.trn = 1'b0;
    repeat (1022) tick();
    bus.tlp_done = 1'b1; tick(); bus.tlp_done = 1'b0;
    chk("wdd.drvn", 64'(bus.drvn), 64'd0);
    chk("wdd.tmo", 64'(bus.timeout_err), 64'd0);

    // T6: reset mid-DRIVE with 2 descriptors queued
    do_reset();
    push(64'h91); push(64'h92); push(64'h93);
    bus.trn = 1'b1; tick(); bus.trn = 1'b0;
    chk("rd.drvn_pre", 64'(bus.drvn), 64'd1);
    chk("rd.pend_pre", 64'(bus.pending), 64'd2);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rd.drvn", 64'(bus.drvn), 64'd0);
    chk("rd.reqep", 64'(bus.reqep), 64'd0);
    chk("rd.pend", 64'(bus.pending), 64'd0);
    chk("rd.rdy", 64'(bus.desc_ready), 64'd1);
    tick();
    chk("rd.reqep_after", 64'(bus.reqep), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
